// File: rtl/lsu_store_queue_if.sv
// Store-queue bus bundle: LSU enqueue/commit/probe side (master) and the queue itself (slave).
interface lsu_store_queue_if #(
    parameter int COMMIT_W = 2,
    parameter int ID_W     = 6,
    parameter int ADDR_W   = 32
);
    logic                enq_valid;
    logic                enq_ready;
    logic [ID_W-1:0]     enq_id;
    logic [ADDR_W-1:0]   enq_addr;
    logic [1:0]          enq_size;
    logic [31:0]         enq_data;
    logic                enq_cache;
    logic [COMMIT_W-1:0] commit;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_data;
    logic [3:0]          mem_strobe;
    logic                mem_cache;
    logic [ADDR_W-1:0]   ld_addr;
    logic [1:0]          ld_size;
    logic                ld_hit;
    logic [31:0]         ld_data;
    logic                ld_conflict;

    modport master (
        output enq_valid, enq_id, enq_addr, enq_size, enq_data, enq_cache, commit,
        output mem_ready, ld_addr, ld_size,
        input  enq_ready, mem_valid, mem_addr, mem_data, mem_strobe, mem_cache,
        input  ld_hit, ld_data, ld_conflict
    );

    modport slave (
        input  enq_valid, enq_id, enq_addr, enq_size, enq_data, enq_cache, commit,
        input  mem_ready, ld_addr, ld_size,
        output enq_ready, mem_valid, mem_addr, mem_data, mem_strobe, mem_cache,
        output ld_hit, ld_data, ld_conflict
    );
endinterface

// File: rtl/lsu_store_queue.sv
// In-order LSU store queue: speculative enqueue, multi-wide commit, single drain port,
// and combinational store-to-load forwarding from the youngest overlapping entry.
module lsu_store_queue #(
    parameter int DEPTH    = 8,
    parameter int COMMIT_W = 2,
    parameter int ID_W     = 6,
    parameter int ADDR_W   = 32,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int PTR_W   = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    lsu_store_queue_if.slave sq,
    output logic [PTR_W-1:0] count_o,
    output logic             commit_err_o
);

    function automatic logic [3:0] lane_strobe(input logic [1:0] a, input logic [1:0] size);
        case (size)
            2'd0:    lane_strobe = 4'b0001 << a;
            2'd1:    lane_strobe = 4'b0011 << {a[1], 1'b0};
            default: lane_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    lane_data = {4{d[7:0]}};
            2'd1:    lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    logic [PTR_W-1:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic              err_q, err_d;
    logic [ADDR_W-3:0] waddr_q [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [3:0]        strb_q  [DEPTH];
    logic              cache_q [DEPTH];

    logic [PTR_W-1:0]  count_s, avail_s;
    logic [PTR_W:0]    commit_pop_s;
    logic              full_s, enq_fire_s, drain_fire_s;
    logic [IDX_W-1:0]  head_idx_s, scan_idx_s;
    logic [3:0]        ld_strb_s, sel_strb_s;
    logic [31:0]       sel_data_s;
    logic              sel_found_s, sel_cache_s, sel_cover_s;
    logic              unused_id_s;

    assign unused_id_s = ^sq.enq_id;

    // Pointer, commit and handshake next-state logic
    always_comb begin
        count_s      = tail_q - head_q;
        avail_s      = tail_q - cmt_q;
        full_s       = (count_s == PTR_W'(DEPTH));
        enq_fire_s   = sq.enq_valid && !full_s && !flush_i;
        drain_fire_s = (head_q != cmt_q) && sq.mem_ready;
        head_idx_s   = head_q[IDX_W-1:0];
        commit_pop_s = {(PTR_W+1){1'b0}};
        for (int i = 0; i < COMMIT_W; i++) begin
            commit_pop_s = commit_pop_s + {{PTR_W{1'b0}}, sq.commit[i]};
        end
        // Over-commit clamps to the youngest store rather than running past tail.
        if (commit_pop_s > {1'b0, avail_s}) begin
            cmt_d = tail_q;
            err_d = 1'b1;
        end else begin
            cmt_d = cmt_q + commit_pop_s[PTR_W-1:0];
            err_d = err_q;
        end
        if (flush_i) begin
            tail_d = cmt_d;
        end else if (enq_fire_s) begin
            tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
        head_d = head_q + {{(PTR_W-1){1'b0}}, drain_fire_s};

        sq.enq_ready  = !full_s;
        sq.mem_valid  = (head_q != cmt_q);
        sq.mem_addr   = {waddr_q[head_idx_s], 2'b00};
        sq.mem_data   = data_q[head_idx_s];
        sq.mem_strobe = strb_q[head_idx_s];
        sq.mem_cache  = cache_q[head_idx_s];
        count_o       = count_s;
        commit_err_o  = err_q;
    end

    // Forwarding probe: scan oldest to youngest so the youngest overlap wins
    always_comb begin
        ld_strb_s   = lane_strobe(sq.ld_addr[1:0], sq.ld_size);
        sel_found_s = 1'b0;
        sel_strb_s  = 4'b0000;
        sel_data_s  = 32'h0000_0000;
        sel_cache_s = 1'b0;
        scan_idx_s  = {IDX_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx_s = head_idx_s + IDX_W'(i);
            if ((PTR_W'(i) < count_s) && (waddr_q[scan_idx_s] == sq.ld_addr[ADDR_W-1:2])
                && ((strb_q[scan_idx_s] & ld_strb_s) != 4'b0000)) begin
                sel_found_s = 1'b1;
                sel_strb_s  = strb_q[scan_idx_s];
                sel_data_s  = data_q[scan_idx_s];
                sel_cache_s = cache_q[scan_idx_s];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        sel_cover_s    = ((sel_strb_s & ld_strb_s) == ld_strb_s) && sel_cache_s;
        sq.ld_hit      = sel_found_s && sel_cover_s;
        sq.ld_conflict = sel_found_s && !sel_cover_s;
        sq.ld_data     = (sel_found_s && sel_cover_s) ? sel_data_s : 32'h0000_0000;
    end

    // Pointer and sticky-error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= {PTR_W{1'b0}};
            cmt_q  <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Entry storage; occupancy is tracked purely by the pointers
    always_ff @(posedge clk_i) begin
        if (enq_fire_s) begin
            waddr_q[tail_q[IDX_W-1:0]] <= sq.enq_addr[ADDR_W-1:2];
            data_q[tail_q[IDX_W-1:0]]  <= lane_data(sq.enq_size, sq.enq_data);
            strb_q[tail_q[IDX_W-1:0]]  <= lane_strobe(sq.enq_addr[1:0], sq.enq_size);
            cache_q[tail_q[IDX_W-1:0]] <= sq.enq_cache;
        end
    end

endmodule

// File: tb/tb_lsu_store_queue.sv
// Scoreboard bench for lsu_store_queue: model queue of stores, drains popped and compared at handshake.
module tb_lsu_store_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        cache;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] count;
    logic       commit_err;

    ent_t m_q[$];
    int   m_cmt = 0;
    bit   m_err = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lsu_store_queue_if #(.COMMIT_W(2), .ID_W(6), .ADDR_W(32)) sq ();

    lsu_store_queue #(.DEPTH(DEPTH), .COMMIT_W(2), .ID_W(6), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .sq           (sq),
        .count_o      (count),
        .commit_err_o (commit_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_strb(input logic [31:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001 << a[1:0];
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] tb_data(input logic [1:0] s, input logic [31:0] d);
        case (s)
            2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd0) return a;
        if (s == 2'd1) return {a[31:1], 1'b0};
        return {a[31:2], 2'b00};
    endfunction

    // One clock: check outputs against the model at negedge, then advance the model at posedge.
    task automatic tick();
        ent_t        e;
        bit          hs, rdy;
        int          pop, avail, sel;
        logic [3:0]  ls;
        @(negedge clk);
        chk("count", count, m_q.size());
        chk("enq_ready", sq.enq_ready, m_q.size() < DEPTH);
        chk("mem_valid", sq.mem_valid, m_cmt > 0);
        chk("commit_err", commit_err, m_err);
        if (m_cmt > 0) begin
            chk("mem_addr", sq.mem_addr, {m_q[0].addr[31:2], 2'b00});
            chk("mem_data", sq.mem_data, m_q[0].data);
            chk("mem_strobe", sq.mem_strobe, m_q[0].strb);
            chk("mem_cache", sq.mem_cache, m_q[0].cache);
        end
        ls  = tb_strb(sq.ld_addr, sq.ld_size);
        sel = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].addr[31:2] == sq.ld_addr[31:2] && (m_q[i].strb & ls) != 4'b0000) sel = i;
        end
        if (sel < 0) begin
            chk("ld_hit", sq.ld_hit, 1'b0);
            chk("ld_conflict", sq.ld_conflict, 1'b0);
            chk("ld_data", sq.ld_data, 32'h0);
        end else if ((m_q[sel].strb & ls) == ls && m_q[sel].cache) begin
            chk("ld_hit", sq.ld_hit, 1'b1);
            chk("ld_conflict", sq.ld_conflict, 1'b0);
            chk("ld_data", sq.ld_data, m_q[sel].data);
        end else begin
            chk("ld_hit", sq.ld_hit, 1'b0);
            chk("ld_conflict", sq.ld_conflict, 1'b1);
        end
        rdy = m_q.size() < DEPTH;
        hs  = (m_cmt > 0) && sq.mem_ready;
        @(posedge clk);
        if (hs) begin
            void'(m_q.pop_front());
            m_cmt--;
        end
        pop   = $countones(sq.commit);
        avail = m_q.size() - m_cmt;
        if (pop > avail) begin
            m_cmt = m_q.size();
            m_err = 1'b1;
        end else begin
            m_cmt += pop;
        end
        if (flush) begin
            while (m_q.size() > m_cmt) void'(m_q.pop_back());
        end else if (sq.enq_valid && rdy) begin
            e.addr  = sq.enq_addr;
            e.data  = tb_data(sq.enq_size, sq.enq_data);
            e.strb  = tb_strb(sq.enq_addr, sq.enq_size);
            e.cache = sq.enq_cache;
            m_q.push_back(e);
        end
        #1;
        sq.enq_valid = 1'b0;
        sq.commit    = 2'b00;
        flush        = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input logic c);
        sq.enq_valid = 1'b1;
        sq.enq_id    = 6'($urandom);
        sq.enq_addr  = a;
        sq.enq_size  = s;
        sq.enq_data  = d;
        sq.enq_cache = c;
        tick();
    endtask

    task automatic probe(input logic [31:0] a, input logic [1:0] s);
        sq.ld_addr = a;
        sq.ld_size = s;
        #1;
    endtask

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int          avail, c;
        rst = 1'b1; flush = 1'b0;
        sq.enq_valid = 1'b0; sq.enq_id = 6'd0; sq.enq_addr = 32'h0; sq.enq_size = 2'd0;
        sq.enq_data = 32'h0; sq.enq_cache = 1'b0; sq.commit = 2'b00; sq.mem_ready = 1'b0;
        sq.ld_addr = 32'hF00; sq.ld_size = 2'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_count", count, 4'd0);
        chk("rst_mem_valid", sq.mem_valid, 1'b0);
        chk("rst_enq_ready", sq.enq_ready, 1'b1);
        chk("rst_ld_hit", sq.ld_hit, 1'b0);
        chk("rst_ld_conflict", sq.ld_conflict, 1'b0);
        chk("rst_commit_err", commit_err, 1'b0);

        put(32'h100, 2'd2, 32'hDEAD_BEEF, 1'b1);
        sq.commit = 2'b01;
        tick();
        chk("sw_mem_valid", sq.mem_valid, 1'b1);
        chk("sw_mem_addr", sq.mem_addr, 32'h100);
        chk("sw_mem_strobe", sq.mem_strobe, 4'b1111);
        sq.mem_ready = 1'b1;
        tick();
        chk("sw_drained", count, 4'd0);

        sq.mem_ready = 1'b0;
        put(32'h103, 2'd0, 32'h0000_00AA, 1'b1);
        probe(32'h103, 2'd0);
        chk("lb_hit", sq.ld_hit, 1'b1);
        chk("lb_data", sq.ld_data[31:24], 8'hAA);
        probe(32'h100, 2'd2);
        chk("lw_conflict", sq.ld_conflict, 1'b1);
        chk("lw_no_hit", sq.ld_hit, 1'b0);
        put(32'h180, 2'd2, 32'h1234_5678, 1'b0);
        probe(32'h180, 2'd2);
        chk("uncached_conflict", sq.ld_conflict, 1'b1);
        put(32'h200, 2'd2, 32'h1111_1111, 1'b1);
        put(32'h200, 2'd2, 32'h2222_2222, 1'b1);
        probe(32'h200, 2'd2);
        chk("youngest_hit", sq.ld_hit, 1'b1);
        chk("youngest_data", sq.ld_data, 32'h2222_2222);
        flush = 1'b1;
        tick();
        chk("flush_all_spec", count, 4'd0);

        for (int i = 0; i < DEPTH; i++) begin
            s = 2'($urandom_range(0, 2));
            put(align(32'h400 + 32'($urandom_range(0, 31)), s), s, $urandom, 1'b1);
        end
        chk("full_enq_ready", sq.enq_ready, 1'b0);
        chk("full_count", count, 4'd8);
        put(32'h500, 2'd2, 32'h5555_5555, 1'b1);
        chk("full_drop", count, 4'd8);
        sq.mem_ready = 1'b1;
        sq.commit = 2'b11;
        tick();
        chk("full_still", sq.enq_ready, 1'b0);
        sq.commit = 2'b11;
        tick();
        chk("full_freed", sq.enq_ready, 1'b1);
        chk("full_count7", count, 4'd7);
        repeat (2) begin
            sq.commit = 2'b11;
            tick();
        end
        repeat (DEPTH) tick();
        chk("full_empty", count, 4'd0);

        sq.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h600 + 32'(i * 4), 2'd2, 32'hA000_0000 + 32'(i), 1'b1);
        sq.commit = 2'b11;
        tick();
        flush = 1'b1;
        put(32'h700, 2'd2, 32'h7777_7777, 1'b1);
        chk("flush_keep2", count, 4'd2);
        sq.mem_ready = 1'b1;
        repeat (2) tick();
        chk("flush_drained", count, 4'd0);
        sq.mem_ready = 1'b0;
        put(32'h640, 2'd2, 32'h6400_0000, 1'b1);
        put(32'h644, 2'd2, 32'h6440_0000, 1'b1);
        flush = 1'b1;
        sq.commit = 2'b01;
        tick();
        chk("flush_commit_first", count, 4'd1);
        sq.mem_ready = 1'b1;
        tick();

        chk("err_clear", commit_err, 1'b0);
        sq.commit = 2'b01;
        tick();
        chk("err_set", commit_err, 1'b1);
        chk("err_no_valid", sq.mem_valid, 1'b0);
        put(32'h800, 2'd1, 32'h0000_BEEF, 1'b1);
        sq.commit = 2'b01;
        tick();
        tick();
        chk("err_sticky", commit_err, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                s = 2'($urandom_range(0, 2));
                sq.enq_valid = 1'b1;
                sq.enq_id    = 6'($urandom);
                sq.enq_size  = s;
                sq.enq_addr  = align(32'h300 + 32'($urandom_range(0, 11)), s);
                sq.enq_data  = $urandom;
                sq.enq_cache = ($urandom_range(0, 7) != 0);
            end
            avail = m_q.size() - m_cmt;
            c = $urandom_range(0, (avail < 2) ? avail : 2);
            sq.commit    = (c == 0) ? 2'b00 : ((c == 1) ? 2'b01 : 2'b11);
            flush        = ($urandom_range(0, 19) == 0);
            sq.mem_ready = ($urandom_range(0, 2) != 0);
            s = 2'($urandom_range(0, 2));
            sq.ld_addr   = align(32'h300 + 32'($urandom_range(0, 11)), s);
            sq.ld_size   = s;
            tick();
        end
        flush = 1'b1;
        sq.mem_ready = 1'b1;
        tick();
        repeat (DEPTH + 2) tick();
        chk("final_empty", count, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
